// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: operand/opcode request and result handshake bundle for the EX-stage ALU
interface alu_control_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [3:0]      funct;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            err;
    logic [3:0]      operation;
    modport master (
        output in_valid, alu_op, funct, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, err, operation
    );
    modport slave (
        input  in_valid, alu_op, funct, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, err, operation
    );
endinterface

// File: rtl/alu_control_unit.sv
// alu_control_unit: decodes ALUOp/funct, executes on two operands, registers the result behind valid/ready
module alu_control_unit #(
    parameter int XLEN   = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    alu_control_unit_if.slave  bus
);
    localparam int SHAMT_W = $clog2(XLEN);
    typedef enum logic {IDLE, MUL} state_t;
    state_t               state;
    logic [3:0]           op;
    logic [XLEN-1:0]      res;
    logic [SHAMT_W-1:0]   sh;
    logic [SHAMT_W-1:0]   count;
    logic [XLEN-1:0]      acc;
    logic [XLEN-1:0]      mcand;
    logic [XLEN-1:0]      mplier;
    logic [XLEN-1:0]      sum;
    logic                 accept;
    assign sh          = bus.src_b[SHAMT_W-1:0];
    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign sum         = acc + (mplier[0] ? mcand : '0);
    // map alu_op/funct to an operation code; anything unlisted is illegal (1111)
    always_comb begin
        op = 4'b1111;
        casez ({bus.alu_op, bus.funct})
            6'b00????: op = 4'b0010;
            6'b01????: op = 4'b0110;
            6'b100000: op = 4'b0010;
            6'b101000: op = 4'b0110;
            6'b100111: op = 4'b0000;
            6'b100110: op = 4'b0001;
            6'b100100: op = 4'b0011;
            6'b100001: op = 4'b0100;
            6'b100101: op = 4'b0101;
            6'b101101: op = 4'b0111;
            6'b100010: op = 4'b1000;
            6'b100011: op = 4'b1001;
            6'b11?000: op = MUL_EN ? 4'b1010 : 4'b1111;
            default:   op = 4'b1111;
        endcase
    end
    // single-cycle datapath; MUL and illegal ops yield 0 here (MUL result comes from the iterative path)
    always_comb begin
        res = '0;
        case (op)
            4'b0010: res = bus.src_a + bus.src_b;
            4'b0110: res = bus.src_a - bus.src_b;
            4'b0000: res = bus.src_a & bus.src_b;
            4'b0001: res = bus.src_a | bus.src_b;
            4'b0011: res = bus.src_a ^ bus.src_b;
            4'b0100: res = bus.src_a << sh;
            4'b0101: res = bus.src_a >> sh;
            4'b0111: res = $signed(bus.src_a) >>> sh;
            4'b1000: res = XLEN'($signed(bus.src_a) < $signed(bus.src_b));
            4'b1001: res = XLEN'(bus.src_a < bus.src_b);
            default: res = '0;
        endcase
    end
    // control FSM: single-cycle ops register immediately, MUL runs XLEN shift-add steps before landing
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.err       <= 1'b0;
            bus.operation <= 4'b0000;
            count         <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
        end else if (state == IDLE) begin
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            if (accept && op == 4'b1010) begin
                state         <= MUL;
                mcand         <= bus.src_a;
                mplier        <= bus.src_b;
                acc           <= '0;
                count         <= '0;
                bus.out_valid <= 1'b0;
            end else if (accept) begin
                bus.out_valid <= 1'b1;
                bus.result    <= res;
                bus.zero      <= (res == '0);
                bus.err       <= (op == 4'b1111);
                bus.operation <= op;
            end
        end else begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + SHAMT_W'(1);
            if (count == SHAMT_W'(XLEN - 1)) begin
                state         <= IDLE;
                bus.out_valid <= 1'b1;
                bus.result    <= sum;
                bus.zero      <= (sum == '0);
                bus.err       <= 1'b0;
                bus.operation <= 4'b1010;
            end
        end
    end
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: directed vectors checked against a cycle-level reference model and literals
module tb_alu_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errs = 0;
    always #5 clk = ~clk;
    alu_control_unit_if #(.XLEN(64)) bus ();
    alu_control_unit_if #(.XLEN(64)) bus2 ();
    alu_control_unit #(.XLEN(64), .MUL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
    alu_control_unit #(.XLEN(64), .MUL_EN(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct packed {
        logic        err;
        logic [3:0]  op;
        logic [63:0] res;
    } ref_t;

    typedef struct packed {
        logic [3:0]  f;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    function automatic ref_t mk(input logic [3:0] o, input logic [63:0] v);
        ref_t r;
        r.err = 1'b0;
        r.op  = o;
        r.res = v;
        return r;
    endfunction

    // what the unit must return for one request, straight from the opcode table
    function automatic ref_t model(input logic [1:0] ao, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        ref_t r;
        logic [5:0] s;
        s = b[5:0];
        r.err = 1'b1;
        r.op  = 4'hF;
        r.res = 64'd0;
        if (ao == 2'd0) r = mk(4'h2, a + b);
        else if (ao == 2'd1) r = mk(4'h6, a - b);
        else if (ao == 2'd3) begin
            if (f[2:0] == 3'd0) r = mk(4'hA, a * b);
        end else begin
            case (f)
                4'd0:  r = mk(4'h2, a + b);
                4'd8:  r = mk(4'h6, a - b);
                4'd7:  r = mk(4'h0, a & b);
                4'd6:  r = mk(4'h1, a | b);
                4'd4:  r = mk(4'h3, a ^ b);
                4'd1:  r = mk(4'h4, a << s);
                4'd5:  r = mk(4'h5, a >> s);
                4'd13: r = mk(4'h7, 64'($signed(a) >>> s));
                4'd2:  r = mk(4'h8, {63'd0, $signed(a) < $signed(b)});
                4'd3:  r = mk(4'h9, {63'd0, a < b});
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference timing: output slot, MUL countdown, pending product
    bit   m_ov = 1'b0;
    int   m_cnt = 0;
    ref_t m_out = '0;
    ref_t m_pend = '0;
    ref_t m_ref;
    logic m_rdy;
    assign m_rdy = (m_cnt == 0) && (!m_ov || bus.out_ready);
    always_comb m_ref = model(bus.alu_op, bus.funct, bus.src_a, bus.src_b);

    // advance the reference on every rising edge
    always @(posedge clk) begin
        if (!reset) begin
            m_ov  <= 1'b0;
            m_cnt <= 0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ov  <= 1'b1;
                m_out <= m_pend;
            end
        end else if (bus.in_valid && m_rdy && m_ref.op == 4'hA) begin
            m_cnt  <= 64;
            m_pend <= m_ref;
            m_ov   <= 1'b0;
        end else if (bus.in_valid && m_rdy) begin
            m_ov  <= 1'b1;
            m_out <= m_ref;
        end else if (m_ov && bus.out_ready) begin
            m_ov <= 1'b0;
        end
    end

    // compare the DUT to the reference every cycle, mid low phase
    always @(negedge clk) begin
        #2;
        chk("in_ready", 64'(bus.in_ready), 64'(m_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("result", bus.result, m_out.res);
            chk("zero", 64'(bus.zero), 64'(m_out.res == 64'd0));
            chk("err", 64'(bus.err), 64'(m_out.err));
            chk("operation", 64'(bus.operation), 64'(m_out.op));
        end
    end

    task automatic send(input logic [1:0] ao, input logic [3:0] f, input logic [63:0] a, input logic [63:0] b);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.alu_op   = ao;
        bus.funct    = f;
        bus.src_a    = a;
        bus.src_b    = b;
        #1;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("accept_in_time", 64'(t < 200), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic lit(input string name, input logic [63:0] r, input logic z, input logic e, input logic [3:0] o);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_result"}, bus.result, r);
        chk({name, "_zero"}, 64'(bus.zero), 64'(z));
        chk({name, "_err"}, 64'(bus.err), 64'(e));
        chk({name, "_op"}, 64'(bus.operation), 64'(o));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        vec_t vt[8];
        vt[0] = '{4'd7, 64'hF0F0, 64'hFF00, 64'hF000};
        vt[1] = '{4'd6, 64'hF0F0, 64'h0F00, 64'hFFF0};
        vt[2] = '{4'd4, 64'hFF, 64'h0F, 64'hF0};
        vt[3] = '{4'd1, 64'd1, 64'd65, 64'd2};
        vt[4] = '{4'd5, 64'h8000_0000_0000_0000, 64'd63, 64'd1};
        vt[5] = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
        vt[6] = '{4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
        vt[7] = '{4'd8, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
        bus.in_valid = 1'b0; bus.alu_op = 2'd0; bus.funct = 4'd0;
        bus.src_a = 64'd0; bus.src_b = 64'd0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.alu_op = 2'd0; bus2.funct = 4'd0;
        bus2.src_a = 64'd0; bus2.src_b = 64'd0; bus2.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_zero", 64'(bus.zero), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_op", 64'(bus.operation), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        send(2'd2, 4'd0, 64'd5, 64'd7);
        lit("add", 64'd12, 1'b0, 1'b0, 4'h2);
        send(2'd1, 4'd0, 64'd3, 64'd3);
        lit("beq", 64'd0, 1'b1, 1'b0, 4'h6);
        send(2'd2, 4'd8, 64'd9, 64'd4);
        lit("sub_b2b", 64'd5, 1'b0, 1'b0, 4'h6);
        send(2'd3, 4'd0, 64'd6, 64'd7);
        #1;
        chk("mul_in_ready", 64'(bus.in_ready), 64'd0);
        wait_out(n);
        chk("mul_latency", 64'(n), 64'd64);
        lit("mul", 64'd42, 1'b0, 1'b0, 4'hA);
        send(2'd3, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_out(n);
        chk("mul2_latency", 64'(n), 64'd64);
        lit("mul2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4'hA);
        send(2'd2, 4'd13, 64'h8000_0000_0000_0000, 64'h44);
        bus.out_ready = 1'b0;
        lit("sra", 64'hF800_0000_0000_0000, 1'b0, 1'b0, 4'h7);
        bus.in_valid = 1'b1;
        bus.alu_op = 2'd2; bus.funct = 4'd0; bus.src_a = 64'd1; bus.src_b = 64'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
            lit("hold", 64'hF800_0000_0000_0000, 1'b0, 1'b0, 4'h7);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        send(2'd3, 4'd0, 64'd6, 64'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mul_out_valid", 64'(bus.out_valid), 64'd0);
        #1;
        chk("rst_mul_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        send(2'd2, 4'd0, 64'd1, 64'd1);
        lit("add_after_rst", 64'd2, 1'b0, 1'b0, 4'h2);
        send(2'd2, 4'd15, 64'd5, 64'd5);
        lit("illegal", 64'd0, 1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 8; i++) begin
            send(2'd2, vt[i].f, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d", i), bus.result, vt[i].exp);
        end
        bus2.in_valid = 1'b1;
        bus2.alu_op = 2'd3; bus2.funct = 4'd0; bus2.src_a = 64'd6; bus2.src_b = 64'd7;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        chk("nomul_valid", 64'(bus2.out_valid), 64'd1);
        chk("nomul_err", 64'(bus2.err), 64'd1);
        chk("nomul_result", bus2.result, 64'd0);
        chk("nomul_zero", 64'(bus2.zero), 64'd1);
        chk("nomul_op", 64'(bus2.operation), 64'hF);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
